// File: rtl/sys_cmd_ctrl.sv
// Command-frame controller: decodes received byte frames into register-file
// accesses and ALU operations, and returns read/ALU results through the transmitter.
module sys_cmd_ctrl #(
    parameter int unsigned width     = 8,
    parameter int unsigned depth     = 16,
    parameter int unsigned OUT_width = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [width-1:0]           Rx_P_Data,
    input  logic                       RxValid,
    output logic                       WrEN,
    output logic                       RdEN,
    output logic [$clog2(depth)-1:0]   Reg_File_Adress,
    output logic [width-1:0]           WrData,
    input  logic [width-1:0]           RdData,
    input  logic                       Rd_valid,
    output logic                       ALU_EN,
    output logic [3:0]                 ALU_FUN,
    input  logic [OUT_width-1:0]       ALU_out,
    input  logic                       ALU_out_valid,
    output logic                       CLK_GATE_EN,
    output logic [width-1:0]           Tx_Data,
    output logic                       Tx_Data_valid,
    input  logic                       Busy,
    input  logic                       Ser_done,
    output logic                       Frame_error
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned NB = OUT_width / width;
    localparam int unsigned BW = $clog2(NB + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [width-1:0] CMD_WR    = width'(8'hAA);
    localparam logic [width-1:0] CMD_RD    = width'(8'hBB);
    localparam logic [width-1:0] CMD_ALU   = width'(8'hCC);
    localparam logic [width-1:0] CMD_ALU_N = width'(8'hDD);
    localparam logic [width-1:0] CMD_BWR   = width'(8'hEE);
    localparam logic [width-1:0] CMD_BRD   = width'(8'hFF);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_CNT, GET_DATA, GET_A, GET_B, GET_FUN,
        RD_REQ, RD_WAIT, ALU_RUN, ALU_WAIT, TX_SEND, TX_WAIT
    } state_t;

    state_t               state;
    logic [width-1:0]     cmd;
    logic [AW-1:0]        addr;
    logic [width-1:0]     cnt;
    logic [OUT_width-1:0] tx_buf;
    logic [BW-1:0]        tx_left;
    logic [TW-1:0]        timer;
    logic                 in_get_c;
    logic                 timeout_c;
    logic [AW-1:0]        addr_inc_c;

    always_comb begin
        in_get_c   = (state == GET_ADDR) || (state == GET_CNT) || (state == GET_DATA) ||
                     (state == GET_A) || (state == GET_B) || (state == GET_FUN);
        timeout_c  = in_get_c && !RxValid && (timer == TW'(TIMEOUT - 1));
        // burst addresses wrap at depth-1 even when depth is not a power of two
        addr_inc_c = (addr == AW'(depth - 1)) ? '0 : addr + AW'(1);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state           <= IDLE;
            cmd             <= '0;
            addr            <= '0;
            cnt             <= '0;
            tx_buf          <= '0;
            tx_left         <= '0;
            timer           <= '0;
            WrEN            <= 1'b0;
            RdEN            <= 1'b0;
            Reg_File_Adress <= '0;
            WrData          <= '0;
            ALU_EN          <= 1'b0;
            ALU_FUN         <= '0;
            CLK_GATE_EN     <= 1'b0;
            Tx_Data         <= '0;
            Tx_Data_valid   <= 1'b0;
            Frame_error     <= 1'b0;
        end else begin
            WrEN          <= 1'b0;
            RdEN          <= 1'b0;
            ALU_EN        <= 1'b0;
            Tx_Data_valid <= 1'b0;
            Frame_error   <= 1'b0;
            timer         <= (in_get_c && !RxValid) ? timer + TW'(1) : '0;

            if (timeout_c) begin
                Frame_error <= 1'b1;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: if (RxValid) begin
                        cmd <= Rx_P_Data;
                        case (Rx_P_Data)
                            CMD_WR, CMD_RD, CMD_BWR, CMD_BRD: state <= GET_ADDR;
                            CMD_ALU:   state <= GET_A;
                            CMD_ALU_N: state <= GET_FUN;
                            default:   Frame_error <= 1'b1;
                        endcase
                    end
                    GET_ADDR: if (RxValid) begin
                        addr <= Rx_P_Data[AW-1:0];
                        if (cmd == CMD_RD) begin
                            Reg_File_Adress <= Rx_P_Data[AW-1:0];
                            RdEN            <= 1'b1;
                            state           <= RD_REQ;
                        end else if (cmd == CMD_WR) begin
                            state <= GET_DATA;
                        end else begin
                            state <= GET_CNT;
                        end
                    end
                    GET_CNT: if (RxValid) begin
                        cnt <= Rx_P_Data;
                        if (Rx_P_Data == '0) begin
                            state <= IDLE;
                        end else if (cmd == CMD_BWR) begin
                            state <= GET_DATA;
                        end else begin
                            Reg_File_Adress <= addr;
                            RdEN            <= 1'b1;
                            state           <= RD_REQ;
                        end
                    end
                    GET_DATA: if (RxValid) begin
                        WrEN            <= 1'b1;
                        Reg_File_Adress <= addr;
                        WrData          <= Rx_P_Data;
                        addr            <= addr_inc_c;
                        cnt             <= cnt - width'(1);
                        if (cmd != CMD_BWR || cnt == width'(1)) state <= IDLE;
                    end
                    GET_A: if (RxValid) begin
                        WrEN            <= 1'b1;
                        Reg_File_Adress <= '0;
                        WrData          <= Rx_P_Data;
                        state           <= GET_B;
                    end
                    GET_B: if (RxValid) begin
                        WrEN            <= 1'b1;
                        Reg_File_Adress <= AW'(1);
                        WrData          <= Rx_P_Data;
                        state           <= GET_FUN;
                    end
                    GET_FUN: if (RxValid) begin
                        ALU_FUN     <= Rx_P_Data[3:0];
                        CLK_GATE_EN <= 1'b1;
                        state       <= ALU_RUN;
                    end
                    ALU_RUN: begin
                        ALU_EN <= 1'b1;
                        state  <= ALU_WAIT;
                    end
                    ALU_WAIT: if (ALU_out_valid) begin
                        tx_buf      <= ALU_out;
                        tx_left     <= BW'(NB);
                        CLK_GATE_EN <= 1'b0;
                        state       <= TX_SEND;
                    end
                    RD_REQ, RD_WAIT: begin
                        if (Rd_valid) begin
                            tx_buf  <= OUT_width'(RdData);
                            tx_left <= BW'(1);
                            state   <= TX_SEND;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                    TX_SEND: if (!Busy) begin
                        Tx_Data       <= tx_buf[width-1:0];
                        Tx_Data_valid <= 1'b1;
                        state         <= TX_WAIT;
                    end
                    TX_WAIT: if (Ser_done) begin
                        if (tx_left > BW'(1)) begin
                            // ALU results go out least-significant byte first
                            tx_buf  <= tx_buf >> width;
                            tx_left <= tx_left - BW'(1);
                            state   <= TX_SEND;
                        end else if (cmd == CMD_BRD && cnt > width'(1)) begin
                            cnt             <= cnt - width'(1);
                            addr            <= addr_inc_c;
                            Reg_File_Adress <= addr_inc_c;
                            RdEN            <= 1'b1;
                            state           <= RD_REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl with behavioural register-file, ALU and
// transmitter responders driven on the falling clock edge.
module tb_sys_cmd_ctrl;

    localparam int unsigned TO = 1024;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [7:0]  Rx_P_Data;
    logic        RxValid;
    logic        WrEN, RdEN;
    logic [3:0]  Reg_File_Adress;
    logic [7:0]  WrData;
    logic [7:0]  RdData;
    logic        Rd_valid;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_out;
    logic        ALU_out_valid;
    logic        CLK_GATE_EN;
    logic [7:0]  Tx_Data;
    logic        Tx_Data_valid;
    logic        Busy;
    logic        Ser_done;
    logic        Frame_error;

    sys_cmd_ctrl #(.width(8), .depth(16), .OUT_width(16), .TIMEOUT(TO)) dut (
        .CLK(CLK), .Reset(Reset), .Rx_P_Data(Rx_P_Data), .RxValid(RxValid),
        .WrEN(WrEN), .RdEN(RdEN), .Reg_File_Adress(Reg_File_Adress), .WrData(WrData),
        .RdData(RdData), .Rd_valid(Rd_valid), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .ALU_out(ALU_out), .ALU_out_valid(ALU_out_valid), .CLK_GATE_EN(CLK_GATE_EN),
        .Tx_Data(Tx_Data), .Tx_Data_valid(Tx_Data_valid), .Busy(Busy),
        .Ser_done(Ser_done), .Frame_error(Frame_error)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // register file model and write/read logs
    logic [7:0]  mem [16];
    logic [11:0] wr_q [$];
    int          rd_n = 0;
    always @(negedge CLK) begin
        Rd_valid = 1'b0;
        if (!Reset) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'h00;
            RdData = 8'h00;
        end else begin
            if (WrEN) begin
                mem[Reg_File_Adress] = WrData;
                wr_q.push_back({Reg_File_Adress, WrData});
            end
            if (RdEN) begin
                rd_n++;
                Rd_valid = 1'b1;
                RdData   = mem[Reg_File_Adress];
            end
        end
    end

    // ALU model: result two cycles after ALU_EN
    logic [15:0] alu_result;
    int          alu_cnt = 0;
    int          alu_en_n = 0;
    logic [3:0]  fun_seen;
    logic        cg_seen;
    always @(negedge CLK) begin
        ALU_out_valid = 1'b0;
        ALU_out       = alu_result;
        if (!Reset) begin
            alu_cnt = 0;
        end else begin
            if (alu_cnt != 0) begin
                alu_cnt--;
                if (alu_cnt == 0) ALU_out_valid = 1'b1;
            end
            if (ALU_EN) begin
                alu_cnt  = 2;
                alu_en_n++;
                fun_seen = ALU_FUN;
                cg_seen  = CLK_GATE_EN;
            end
        end
    end

    // transmitter model: busy for three cycles per byte, Ser_done at the end
    logic [7:0] tx_q [$];
    int         tx_cnt = 0;
    logic       tx_busy = 1'b0;
    logic       hold_busy = 1'b0;
    logic [7:0] tx_last = 8'h00;
    int         stab_err = 0;
    int         txv_busy_err = 0;
    always @(negedge CLK) begin
        Ser_done = 1'b0;
        if (!Reset) begin
            tx_cnt  = 0;
            tx_busy = 1'b0;
        end else begin
            if (tx_busy && Tx_Data !== tx_last) stab_err++;
            if (Tx_Data_valid && Busy) txv_busy_err++;
            if (tx_cnt != 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    Ser_done = 1'b1;
                    tx_busy  = 1'b0;
                end
            end
            if (Tx_Data_valid) begin
                tx_q.push_back(Tx_Data);
                tx_last = Tx_Data;
                tx_busy = 1'b1;
                tx_cnt  = 3;
            end
        end
        Busy = tx_busy | hold_busy;
    end

    int fe_n = 0;
    always @(negedge CLK) if (Frame_error) fe_n++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        Rx_P_Data = b;
        RxValid   = 1'b1;
        @(posedge CLK); #1;
        RxValid   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({WrEN, RdEN, ALU_EN, CLK_GATE_EN, Tx_Data_valid, Frame_error}), 32'h0);
        chk({tag, "_dat"}, 32'({Reg_File_Adress, WrData, ALU_FUN, Tx_Data}), 32'h0);
    endtask

    int wb, tb0, rb, fb;

    initial begin
        Reset      = 1'b0;
        Rx_P_Data  = 8'h00;
        RxValid    = 1'b0;
        alu_result = 16'h0000;

        idle(3);
        chk_all_zero("reset");
        Reset = 1'b1;
        idle(2);

        // single write
        send(8'hAA); send(8'h05); send(8'h3C);
        chk("wr_pulse", 32'(WrEN), 32'h1);
        chk("wr_addr_data", 32'({Reg_File_Adress, WrData}), 32'h53C);
        idle(1);
        chk("wr_pulse_end", 32'(WrEN), 32'h0);
        idle(5);
        chk("wr_count", 32'(wr_q.size()), 32'd1);

        // read with the transmitter held busy, then released
        tb0 = tx_q.size(); rb = rd_n;
        hold_busy = 1'b1;
        idle(2);
        send(8'hBB); send(8'h05);
        idle(15);
        chk("rd_count", 32'(rd_n - rb), 32'd1);
        chk("busy_stall_no_tx", 32'(tx_q.size() - tb0), 32'd0);
        hold_busy = 1'b0;
        idle(15);
        chk("rd_tx_count", 32'(tx_q.size() - tb0), 32'd1);
        chk("rd_tx_data", 32'(tx_q[tb0]), 32'h3C);

        // ALU with operands
        wb = wr_q.size(); tb0 = tx_q.size();
        alu_result = 16'h0046;
        send(8'hCC); send(8'h12); send(8'h34); send(8'h00);
        idle(40);
        chk("alu_wr_count", 32'(wr_q.size() - wb), 32'd2);
        chk("alu_wr_a", 32'(wr_q[wb]), 32'h012);
        chk("alu_wr_b", 32'(wr_q[wb+1]), 32'h134);
        chk("alu_en_count", 32'(alu_en_n), 32'd1);
        chk("alu_fun", 32'(fun_seen), 32'h0);
        chk("alu_gate_at_en", 32'(cg_seen), 32'h1);
        chk("alu_tx_count", 32'(tx_q.size() - tb0), 32'd2);
        chk("alu_tx_lsb", 32'(tx_q[tb0]), 32'h46);
        chk("alu_tx_msb", 32'(tx_q[tb0+1]), 32'h00);
        chk("alu_gate_off", 32'(CLK_GATE_EN), 32'h0);

        // ALU without operands
        tb0 = tx_q.size();
        alu_result = 16'hBEEF;
        send(8'hDD); send(8'h15);
        idle(40);
        chk("alun_fun", 32'(fun_seen), 32'h5);
        chk("alun_tx_lsb", 32'(tx_q[tb0]), 32'hEF);
        chk("alun_tx_msb", 32'(tx_q[tb0+1]), 32'hBE);

        // burst write wrapping 15 -> 0
        wb = wr_q.size();
        send(8'hEE); send(8'h0E); send(8'h03); send(8'hA1); send(8'hA2); send(8'hA3);
        idle(5);
        chk("bwr_count", 32'(wr_q.size() - wb), 32'd3);
        chk("bwr_0", 32'(wr_q[wb]), 32'hEA1);
        chk("bwr_1", 32'(wr_q[wb+1]), 32'hFA2);
        chk("bwr_2", 32'(wr_q[wb+2]), 32'h0A3);

        // burst read wrapping 15 -> 0
        tb0 = tx_q.size(); rb = rd_n;
        send(8'hFF); send(8'h0F); send(8'h02);
        idle(40);
        chk("brd_rd_count", 32'(rd_n - rb), 32'd2);
        chk("brd_tx_count", 32'(tx_q.size() - tb0), 32'd2);
        chk("brd_tx_0", 32'(tx_q[tb0]), 32'hA2);
        chk("brd_tx_1", 32'(tx_q[tb0+1]), 32'hA3);

        // zero-length bursts, then a normal write proves the FSM is in IDLE
        wb = wr_q.size(); tb0 = tx_q.size(); rb = rd_n;
        send(8'hEE); send(8'h03); send(8'h00);
        send(8'hFF); send(8'h03); send(8'h00);
        idle(10);
        chk("n0_no_access", 32'((wr_q.size() - wb) + (rd_n - rb) + (tx_q.size() - tb0)), 32'd0);
        send(8'hAA); send(8'h06); send(8'h55);
        idle(3);
        chk("n0_then_wr", 32'(wr_q[wb]), 32'h655);

        // inter-byte timeout
        wb = wr_q.size(); fb = fe_n;
        send(8'hAA); send(8'h05);
        idle(TO - 1);
        chk("to_not_yet", 32'(Frame_error), 32'h0);
        idle(1);
        chk("to_fe", 32'(Frame_error), 32'h1);
        idle(1);
        chk("to_fe_end", 32'(Frame_error), 32'h0);
        idle(3);
        chk("to_fe_count", 32'(fe_n - fb), 32'd1);
        chk("to_no_wr", 32'(wr_q.size() - wb), 32'd0);

        // illegal command byte
        send(8'h77);
        chk("bad_cmd_fe", 32'(Frame_error), 32'h1);
        idle(1);
        chk("bad_cmd_fe_end", 32'(Frame_error), 32'h0);

        // reset while the second byte of a burst read is on the wire
        tb0 = tx_q.size();
        send(8'hFF); send(8'h00); send(8'h04);
        for (int i = 0; i < 200 && (tx_q.size() - tb0) < 2; i++) @(posedge CLK);
        #1;
        chk("brst_progress", 32'(tx_q.size() - tb0), 32'd2);
        Reset = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        idle(2);
        Reset = 1'b1;
        wb = wr_q.size(); tb0 = tx_q.size(); rb = rd_n;
        idle(40);
        chk("post_rst_no_access", 32'((wr_q.size() - wb) + (rd_n - rb) + (tx_q.size() - tb0)), 32'd0);

        chk("tx_data_stable", 32'(stab_err), 32'd0);
        chk("tx_valid_while_busy", 32'(txv_busy_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sys_cmd_ctrl.md
SYS_CMD_CTRL -- requirements
Module: sys_cmd_ctrl

Interface
REQ-001 Parameters SHALL be: width, 8, data/register width; depth, 16, register-file depth; OUT_width, 16, ALU result width (integer multiple of width); TIMEOUT, 1024, max idle cycles between frame bytes.
REQ-002 Ports SHALL be: CLK  in  1  system clock; Reset  in  1  asynchronous active-low reset.
REQ-003 Rx_P_Data in width, received byte; RxValid in 1, one-cycle byte strobe.
REQ-004 WrEN out 1, RdEN out 1, Reg_File_Adress out $clog2(depth), WrData out width, register-file controls; RdData in width, Rd_valid in 1, read return.
REQ-005 ALU_EN out 1, ALU_FUN out 4, ALU_out in OUT_width, ALU_out_valid in 1, ALU control and result; CLK_GATE_EN out 1, ALU clock-gate enable.
REQ-006 Tx_Data out width, Tx_Data_valid out 1, transmit byte and strobe; Busy in 1, transmitter busy; Ser_done in 1, one-cycle byte-sent pulse.
REQ-007 Frame_error out 1, one-cycle pulse on aborted or illegal frame.

Function
REQ-008 Commands SHALL be keyed by the first byte: 0xAA write (ADDR, DATA); 0xBB read (ADDR); 0xCC ALU with operands (A, B, FUN); 0xDD ALU without operands (FUN); 0xEE burst write (ADDR, N, N data bytes); 0xFF burst read (ADDR, N).
REQ-009 Any other first byte SHALL pulse Frame_error one cycle after its RxValid and leave the FSM in IDLE.
REQ-010 FSM states SHALL be IDLE, GET_ADDR, GET_CNT, GET_DATA, GET_A, GET_B, GET_FUN, RD_REQ, RD_WAIT, ALU_RUN, ALU_WAIT, TX_SEND, TX_WAIT.
REQ-011 Addresses SHALL use the low $clog2(depth) bits of ADDR; burst addresses SHALL increment by 1 per byte, wrapping depth-1 -> 0.
REQ-012 Register write: WrEN SHALL pulse exactly one cycle, the cycle after the DATA RxValid, with Reg_File_Adress and WrData valid in that cycle.
REQ-013 0xCC: A SHALL be written to address 0 and B to address 1 using REQ-012 timing.
REQ-014 Register read: RdEN SHALL pulse one cycle in RD_REQ; RdData SHALL be captured on Rd_valid and the FSM SHALL move to TX_SEND.
REQ-015 ALU: CLK_GATE_EN SHALL rise on entry to ALU_RUN; ALU_EN SHALL pulse one cycle the next cycle with ALU_FUN = FUN[3:0]; ALU_FUN SHALL be held until ALU_out_valid; ALU_out SHALL be captured on ALU_out_valid, which SHALL also drop CLK_GATE_EN.
REQ-016 The ALU result SHALL be sent as OUT_width/width bytes, least-significant byte first.
REQ-017 TX_SEND: Tx_Data_valid SHALL pulse one cycle only while Busy=0, Tx_Data stable from that cycle until Ser_done; TX_WAIT SHALL wait for Ser_done before the next byte or IDLE.
REQ-018 Burst write N: one WrEN per data byte at successive addresses; burst read N: read-then-transmit per byte at successive addresses; N=0 SHALL return to IDLE with no access and no Tx.
REQ-019 RxValid arriving outside a GET_* or IDLE state SHALL be ignored (byte dropped).
REQ-020 In any GET_* state, TIMEOUT cycles without RxValid SHALL pulse Frame_error and return to IDLE; the counter SHALL reset on every accepted byte.
REQ-021 Simultaneous Busy=1 and pending send SHALL stall in TX_SEND with no Tx_Data_valid.

Reset
REQ-022 Reset low SHALL immediately force IDLE and drive WrEN, RdEN, ALU_EN, CLK_GATE_EN, Tx_Data_valid, Frame_error to 0 and Reg_File_Adress, WrData, ALU_FUN, Tx_Data, captured data and counters to 0.
REQ-023 Reset asserted mid-frame or mid-burst SHALL discard the frame; no access SHALL occur after deassertion until a new command byte.

Verification
REQ-024 Bytes AA,05,3C -> one WrEN pulse, Reg_File_Adress=5, WrData=0x3C.
REQ-025 Bytes BB,05 with RdData=0x3C -> one RdEN, one Tx_Data_valid with Tx_Data=0x3C after Busy=0.
REQ-026 Bytes CC,12,34,00, ALU_out=0x0046 -> writes 0x12@0, 0x34@1, ALU_EN with ALU_FUN=0, Tx bytes 0x46 then 0x00, CLK_GATE_EN low afterwards.
REQ-027 Bytes EE,0E,03,A1,A2,A3 -> WrEN at addresses 14,15,0 with 0xA1,0xA2,0xA3.
REQ-028 Bytes AA,05 then TIMEOUT idle cycles -> Frame_error pulse, no WrEN; byte 0x77 in IDLE -> Frame_error pulse.
REQ-029 Reset low during FF,00,04 transmit of byte 2 -> all outputs 0, no further Tx_Data_valid after release.
